// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, start/done handshake.
// Optional build macro BLANK_LEADING_EN replaces leading zero digits (dig1..dig3) with 4'hF.
module bin_to_bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic [3:0]       dig4,
  output logic             ovf
);

  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nx;
  logic [BIN_W-1:0] bin_reg, bin_nx;
  logic [15:0]      scratch, scratch_adj, scratch_nx, final_dig;
  logic [CW-1:0]    cnt;
  logic             ovf_pending;
  logic             last;
  logic             in_ovf;

  assign last   = (cnt == CW'(1));
  assign in_ovf = ({{(32-BIN_W){1'b0}}, bin_in} > 32'd9999);

  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    scratch_nx = {scratch_adj[14:0], bin_reg[BIN_W-1]};
    bin_nx     = {bin_reg[BIN_W-2:0], 1'b0};
  end

  // Digits presented at completion: saturated on overflow, optionally leading-blanked.
  always_comb begin
    final_dig = ovf_pending ? 16'h9999 : scratch_nx;
`ifdef BLANK_LEADING_EN
    if (!ovf_pending && final_dig[15:12] == 4'd0) begin
      final_dig[15:12] = 4'hF;
      if (final_dig[11:8] == 4'd0) begin
        final_dig[11:8] = 4'hF;
        if (final_dig[7:4] == 4'd0) final_dig[7:4] = 4'hF;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      bin_reg     <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      dig1        <= '0;
      dig2        <= '0;
      dig3        <= '0;
      dig4        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg     <= bin_in;
            scratch     <= '0;
            cnt         <= CW'(BIN_W);
            ovf_pending <= in_ovf;
          end
        end
        SHIFT: begin
          bin_reg <= bin_nx;
          scratch <= scratch_nx;
          cnt     <= cnt - CW'(1);
          if (last) begin
            done <= 1'b1;
            ovf  <= ovf_pending;
            dig1 <= final_dig[15:12];
            dig2 <= final_dig[11:8];
            dig3 <= final_dig[7:4];
            dig4 <= final_dig[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against an arithmetic BCD reference.
// Build with BLANK_LEADING_EN defined to exercise the leading-blank variant.
module tb_bin_to_bcd_seq;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy, done, ovf;
  logic [3:0]       dig1, dig2, dig3, dig4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] shown;
  logic        shown_ovf;

  bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk(clk), .clr(clr), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .ovf(ovf)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] ref_digits(input int v);
    int d[4];
    if (v > 9999) return 16'h9999;
    d[0] = v / 1000;
    d[1] = (v / 100) % 10;
    d[2] = (v / 10) % 10;
    d[3] = v % 10;
`ifdef BLANK_LEADING_EN
    for (int i = 0; i < 3 && d[i] == 0; i++) d[i] = 15;
`endif
    return {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
  endfunction

  function automatic int digits_now();
    return int'({dig1, dig2, dig3, dig4});
  endfunction

  // Caller sits at a negedge; start is accepted on the next posedge.
  task automatic launch(input int v);
    bin_in = BIN_W'(v);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // k0 = edges already elapsed since the accepting edge.
  task automatic wait_done(input int k0, input int v);
    int k = k0;
    while (!done && k < 40) begin
      check("busy_during", busy, 1);
      check("dig_hold", digits_now(), int'(shown));
      @(negedge clk);
      k++;
    end
    check("latency", k, BIN_W);
    shown     = ref_digits(v);
    shown_ovf = (v > 9999);
    check("busy_at_done", busy, 0);
    check("digits", digits_now(), int'(shown));
    check("ovf", ovf, int'(shown_ovf));
  endtask

  task automatic convert(input int v);
    @(negedge clk);
    launch(v);
    wait_done(0, v);
  endtask

  initial begin
    int v;
    clr = 1'b0; start = 1'b1; bin_in = BIN_W'(1234);
    shown = 16'h0000; shown_ovf = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_digits", digits_now(), 0);
    end
    clr = 1'b1; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    convert(1234);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    convert(0);
    launch(9999);
    wait_done(0, 9999);

    convert(12000);
    convert(7);

    // start while busy is ignored
    @(negedge clk);
    launch(1234);
    repeat (4) @(negedge clk);
    bin_in = BIN_W'(5678); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, 1234);

    // reset mid-conversion aborts with no done pulse
    @(negedge clk);
    launch(5678);
    repeat (6) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    shown = 16'h0000; shown_ovf = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_digits", digits_now(), 0);
    check("abort_ovf", ovf, 0);
    begin
      int saw_done = 0;
      repeat (20) begin
        @(negedge clk);
        if (done) saw_done = 1;
      end
      check("abort_no_done", saw_done, 0);
    end

`ifdef BLANK_LEADING_EN
    convert(42);
    convert(0);
    convert(1005);
`endif

    for (int i = 0; i < 24; i++) begin
      v = (i % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      if (i % 3 == 0 && i > 0) begin
        launch(v);
        wait_done(0, v);
      end else begin
        convert(v);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
